i2c_slave_receiver: RTL and testbench

I2C_SLAVE_RECEIVER -- requirements
Module: i2c_slave_receiver

---
 rtl/i2c_slave_receiver.sv | 138 +++++++++++++
 tb/tb_i2c_slave_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C responder: ACKs SLAVE_ADDRESS, latches a register pointer, then
// strobes each following data byte out with an auto-incrementing pointer.
module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       i2c_busy,
    output logic [7:0] i2c_status
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic [7:0]             rx_byte, ptr;
    logic                   byte_done, addr_match, ack_on;
    logic [5:0]             status;

    // Flops reset to 1 so an idle bus never looks like a START on exit from reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign rx_byte    = {shift, sda_s};
    assign byte_done  = scl_rise && (bit_cnt == 3'd7);
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDRESS) && !rx_byte[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ADDR:     if (byte_done) state_n = addr_match ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (scl_fall && ack_on) state_n = REG;
            REG:      if (byte_done) state_n = REG_ACK;
            REG_ACK:  if (scl_fall && ack_on) state_n = DATA;
            DATA:     if (byte_done) state_n = DATA_ACK;
            DATA_ACK: if (scl_fall && ack_on) state_n = DATA;
            default:  state_n = state;
        endcase
        if (start_det) state_n = ADDR;
        if (stop_det)  state_n = IDLE;
    end

    // ack_on toggles on the two SCL falls bracketing the 9th clock, so SDA only
    // moves while SCL is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            ptr      <= 8'd0;
            ack_on   <= 1'b0;
            wr_reg   <= 8'd0;
            wr_data  <= 8'd0;
            wr_valid <= 1'b0;
            i2c_busy <= 1'b0;
            status   <= 6'd0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                bit_cnt  <= 3'd0;
                ack_on   <= 1'b0;
                i2c_busy <= 1'b1;
                status   <= {i2c_busy, 5'd0};
            end else if (stop_det) begin
                bit_cnt   <= 3'd0;
                ack_on    <= 1'b0;
                i2c_busy  <= 1'b0;
                status[4] <= 1'b1;
            end else begin
                if (scl_rise && (state == ADDR || state == REG || state == DATA)) begin
                    shift   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        ADDR: begin
                            status[1] <= status[1] | addr_match;
                            status[0] <= status[0] | ~addr_match;
                        end
                        REG: begin
                            ptr       <= rx_byte;
                            status[2] <= 1'b1;
                        end
                        DATA: begin
                            wr_data   <= rx_byte;
                            wr_reg    <= ptr;
                            wr_valid  <= 1'b1;
                            ptr       <= ptr + 8'd1;
                            status[3] <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (scl_fall && (state == ADDR_ACK || state == REG_ACK || state == DATA_ACK))
                    ack_on <= ~ack_on;
            end
        end
    end

    assign sda_oe     = ack_on;
    assign i2c_status = {2'b00, status};

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bit-banged I2C master driving i2c_slave_receiver; expected ACKs, writes and
// status come from a transaction-level model of the byte stream.
module tb_i2c_slave_receiver;

    localparam logic [6:0] SADDR = 7'h50;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in;
    logic       sda_oe, wr_valid, i2c_busy;
    logic [7:0] wr_reg, wr_data, i2c_status;

    int checks = 0;
    int errors = 0;

    logic [15:0] got[$];
    int          oe_cnt = 0;
    int          dbl    = 0;
    int          viol   = 0;
    logic        prev_v = 1'b0;
    logic        prev_oe = 1'b0;
    logic [7:0]  tx[$];

    always #10 clock = ~clock;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_receiver #(.SLAVE_ADDRESS(SADDR), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .wr_reg(wr_reg), .wr_data(wr_data), .wr_valid(wr_valid),
        .i2c_busy(i2c_busy), .i2c_status(i2c_status)
    );

    always @(posedge clock) begin
        if (wr_valid) got.push_back({wr_reg, wr_data});
        if (wr_valid && prev_v) dbl++;
        if (sda_oe) oe_cnt++;
        if (reset && sda_oe != prev_oe && scl_in) viol++;
        prev_v  = wr_valid;
        prev_oe = sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_c(input int q);
        sda_m = 1'b1; w(q);
        scl_m = 1'b1; w(q);
        sda_m = 1'b0; w(q);
        scl_m = 1'b0; w(q);
    endtask

    task automatic stop_c(input int q);
        sda_m = 1'b0; w(q);
        scl_m = 1'b1; w(q);
        sda_m = 1'b1; w(q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int q);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; w(q);
            scl_m = 1'b1; w(2 * q);
            scl_m = 1'b0; w(q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int q, output logic ack);
        send_bits(b, q);
        sda_m = 1'b1; w(q);
        scl_m = 1'b1; w(q);
        ack = ~sda_in;
        w(q);
        scl_m = 1'b0; w(q);
    endtask

    // Model: only a write to SADDR is ACKed; byte 1 is the pointer, each later
    // byte is a write at pointer+k (mod 256).
    task automatic do_txn(input string tag, input int q, input bit rs);
        int         base, oe0, nexp;
        logic       a;
        bit         match;
        logic [7:0] st, p;
        base  = got.size();
        oe0   = oe_cnt;
        match = (tx[0] == {SADDR, 1'b0});
        start_c(q);
        chk({tag, " busy_start"}, i2c_busy, 1'b1);
        foreach (tx[i]) begin
            send_byte(tx[i], q, a);
            chk($sformatf("%s ack%0d", tag, i), a, match);
        end
        stop_c(q);
        w(6);
        nexp = (match && tx.size() > 2) ? tx.size() - 2 : 0;
        chk({tag, " nwrites"}, got.size() - base, nexp);
        p = (tx.size() > 1) ? tx[1] : 8'h00;
        for (int k = 0; k < nexp && base + k < got.size(); k++) begin
            chk($sformatf("%s wr%0d", tag, k), got[base + k], {p, tx[k + 2]});
            p = p + 8'd1;
        end
        st = match ? (8'h02 | (tx.size() > 1 ? 8'h04 : 8'h00) | (tx.size() > 2 ? 8'h08 : 8'h00))
                   : 8'h01;
        st = st | 8'h10 | (rs ? 8'h20 : 8'h00);
        chk({tag, " status"}, i2c_status, st);
        chk({tag, " busy_end"}, i2c_busy, 1'b0);
        if (!match) chk({tag, " oe_quiet"}, oe_cnt - oe0, 0);
    endtask

    initial begin
        int   q, base, oe0, nd;
        logic a;

        w(3);
        chk("rst sda_oe", sda_oe, 1'b0);
        chk("rst wr_valid", wr_valid, 1'b0);
        chk("rst busy", i2c_busy, 1'b0);
        chk("rst status", i2c_status, 8'h00);
        chk("rst wr_reg", wr_reg, 8'h00);
        chk("rst wr_data", wr_data, 8'h00);
        reset = 1'b1;
        w(5);

        tx = {8'hA0, 8'h12, 8'h5A};
        do_txn("single_100k", 125, 1'b0);
        tx = {8'hA2, 8'h12, 8'h5A};
        do_txn("mismatch", 10, 1'b0);
        tx = {8'hA1};
        do_txn("read", 10, 1'b0);
        tx = {8'hA0, 8'hFF, 8'h01, 8'h02};
        do_txn("wrap", 10, 1'b0);

        base = got.size();
        start_c(10);
        send_byte(8'hA0, 10, a); chk("rs ack0", a, 1'b1);
        send_byte(8'h10, 10, a); chk("rs ack1", a, 1'b1);
        chk("rs no_write", got.size() - base, 0);
        tx = {8'hA0, 8'h20, 8'h33};
        do_txn("rstart", 10, 1'b1);

        // Reset while the pointer byte is being ACKed.
        start_c(10);
        send_byte(8'hA0, 10, a);
        send_bits(8'h34, 10);
        sda_m = 1'b1; w(10);
        chk("rstack oe_before", sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        chk("rstack oe_after", sda_oe, 1'b0);
        chk("rstack busy", i2c_busy, 1'b0);
        w(3);
        reset = 1'b1;
        scl_m = 1'b1; w(10);
        scl_m = 1'b0; w(10);
        oe0  = oe_cnt;
        base = got.size();
        sda_m = 1'b0;
        for (int i = 0; i < 18; i++) begin
            scl_m = 1'b1; w(10);
            scl_m = 1'b0; w(10);
        end
        chk("rstack ignored_oe", oe_cnt - oe0, 0);
        chk("rstack ignored_wr", got.size() - base, 0);
        chk("rstack status", i2c_status, 8'h00);
        tx = {8'hA0, 8'h12, 8'h5A};
        do_txn("after_rst", 10, 1'b0);

        for (int t = 0; t < 8; t++) begin
            q = $urandom_range(8, 15);
            case ($urandom % 3)
                0:       tx = {8'hA0};
                1:       tx = {8'hA1};
                default: tx = {8'($urandom)};
            endcase
            nd = $urandom_range(0, 3);
            tx.push_back(8'($urandom));
            for (int i = 0; i < nd; i++) tx.push_back(8'($urandom));
            do_txn($sformatf("rnd%0d", t), q, 1'b0);
        end

        chk("single_cycle_strobe", dbl, 0);
        chk("oe_stable_scl_high", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
